// File: rtl/spectrum_buf_ctrl.sv
// Ping-pong buffer that captures the first BIN_NUM bins of each FFT frame and
// hands them to the display one bin at a time. Define SPEC_PEAK_HOLD_EN to add bin_peak.
module spectrum_buf_ctrl #(
  parameter int DATA_W      = 16,
  parameter int FFT_LEN     = 128,
  parameter int BIN_NUM     = 64,
  parameter int ADDR_W      = 6,
  parameter int DECAY_SHIFT = 3
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fft_data,
  input  logic              fft_sop,
  input  logic              fft_eop,
  input  logic              fft_valid,
  input  logic              data_req,
  input  logic              bin_done,
  output logic [DATA_W-1:0] bin_data,
  output logic [ADDR_W-1:0] bin_idx,
  output logic              bin_valid,
  output logic              frame_start,
  output logic              frame_drop,
  output logic              frame_err
`ifdef SPEC_PEAK_HOLD_EN
  ,
  output logic [DATA_W-1:0] bin_peak
`endif
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_CAPT = 2'd1;
  localparam logic [1:0] W_SKIP = 2'd2;

  localparam logic [2:0] R_IDLE  = 3'd0;
  localparam logic [2:0] R_WAIT  = 3'd1;
  localparam logic [2:0] R_FETCH = 3'd2;
  localparam logic [2:0] R_OUT   = 3'd3;
  localparam logic [2:0] R_DRAW  = 3'd4;

  localparam logic [1:0] B_FREE    = 2'd0;
  localparam logic [1:0] B_READY   = 2'd1;
  localparam logic [1:0] B_READING = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BIN_NUM - 1);

  if (BIN_NUM > FFT_LEN || DECAY_SHIFT >= DATA_W || (1 << ADDR_W) < BIN_NUM) begin : g_cfg_check
    $error("spectrum_buf_ctrl: inconsistent BIN_NUM/FFT_LEN/ADDR_W/DECAY_SHIFT");
  end

  logic [1:0]        w_state_q, w_state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              wr_en, w_start, w_commit, w_demote;
  logic [ADDR_W:0]   wr_addr;
  logic              sop_v, eop_v;

  logic [2:0]        r_state_q, r_state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic              rd_en, r_claim;

  logic [1:0][1:0]   bank_st_q, bank_st_d;
  logic [DATA_W-1:0] mem_q [2*BIN_NUM];
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] bin_data_q, bin_data_d;
  logic [ADDR_W-1:0] bin_idx_q, bin_idx_d;
  logic              bin_valid_q, bin_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_drop_q, frame_drop_d;
  logic              frame_err_q, frame_err_d;

  assign sop_v = fft_valid & fft_sop;
  assign eop_v = fft_valid & fft_eop;

  // Writer: the bank being filled stays FREE until its eop commits it to READY.
  always_comb begin
    w_state_d   = w_state_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    wr_en       = 1'b0;
    wr_addr     = {wr_bank_q, wr_cnt_q};
    w_start     = 1'b0;
    w_commit    = 1'b0;
    w_demote    = 1'b0;
    frame_err_d = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (sop_v) begin
          w_start = 1'b1;
          if (bank_st_q[0] == B_FREE) begin
            wr_bank_d = 1'b0;
          end else if (bank_st_q[1] == B_FREE) begin
            wr_bank_d = 1'b1;
          end else if (bank_st_q[0] == B_READY) begin
            wr_bank_d = 1'b0;
            w_demote  = 1'b1;
          end else if (bank_st_q[1] == B_READY) begin
            wr_bank_d = 1'b1;
            w_demote  = 1'b1;
          end else begin
            w_start = 1'b0;
          end
          if (w_start) begin
            wr_en     = 1'b1;
            wr_addr   = {wr_bank_d, {ADDR_W{1'b0}}};
            wr_cnt_d  = ADDR_W'(1);
            w_state_d = W_CAPT;
          end
        end
      end
      W_CAPT: begin
        if (sop_v) begin
          frame_err_d = 1'b1;
          wr_en       = 1'b1;
          wr_addr     = {wr_bank_q, {ADDR_W{1'b0}}};
          wr_cnt_d    = ADDR_W'(1);
        end else if (fft_valid) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          if (wr_cnt_q == LAST_IDX) begin
            if (eop_v) begin
              w_commit  = 1'b1;
              w_state_d = W_IDLE;
            end else begin
              w_state_d = W_SKIP;
            end
          end else if (eop_v) begin
            frame_err_d = 1'b1;
            w_state_d   = W_IDLE;
          end
        end
      end
      W_SKIP: begin
        if (sop_v) begin
          frame_err_d = 1'b1;
          wr_en       = 1'b1;
          wr_addr     = {wr_bank_q, {ADDR_W{1'b0}}};
          wr_cnt_d    = ADDR_W'(1);
          w_state_d   = W_CAPT;
        end else if (eop_v) begin
          w_commit  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Display handshake: data_req is held until bin_valid; bin_valid pulses once per
  // bin and bin_data/bin_idx hold until the next pulse; bin_done releases the bin.
  always_comb begin
    r_state_d     = r_state_q;
    rd_bank_d     = rd_bank_q;
    rd_idx_d      = rd_idx_q;
    rd_en         = 1'b0;
    r_claim       = 1'b0;
    bin_data_d    = bin_data_q;
    bin_idx_d     = bin_idx_q;
    bin_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_drop_d  = 1'b0;
    bank_st_d     = bank_st_q;
    case (r_state_q)
      R_IDLE: begin
        if (bank_st_q[0] == B_READY || bank_st_q[1] == B_READY) begin
          rd_bank_d            = (bank_st_q[0] != B_READY);
          r_claim              = 1'b1;
          rd_idx_d             = '0;
          frame_start_d        = 1'b1;
          bank_st_d[rd_bank_d] = B_READING;
          r_state_d            = R_WAIT;
        end
      end
      R_WAIT: begin
        if (data_req) begin
          rd_en     = 1'b1;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: r_state_d = R_OUT;
      R_OUT: begin
        bin_data_d  = rd_data_q;
        bin_idx_d   = rd_idx_q;
        bin_valid_d = 1'b1;
        r_state_d   = R_DRAW;
      end
      R_DRAW: begin
        if (bin_done) begin
          if (rd_idx_q == LAST_IDX) begin
            bank_st_d[rd_bank_q] = B_FREE;
            r_state_d            = R_IDLE;
          end else begin
            rd_idx_d  = rd_idx_q + ADDR_W'(1);
            r_state_d = R_WAIT;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (w_demote) begin
      bank_st_d[wr_bank_d] = B_FREE;
      frame_drop_d         = 1'b1;
    end
    // A READY frame being claimed this very cycle is delivered, not dropped.
    if (w_commit) begin
      bank_st_d[wr_bank_q] = B_READY;
      if (bank_st_q[!wr_bank_q] == B_READY && !r_claim) begin
        bank_st_d[!wr_bank_q] = B_FREE;
        frame_drop_d          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q     <= W_IDLE;
      wr_bank_q     <= 1'b0;
      wr_cnt_q      <= '0;
      r_state_q     <= R_IDLE;
      rd_bank_q     <= 1'b0;
      rd_idx_q      <= '0;
      bank_st_q     <= {B_FREE, B_FREE};
      bin_data_q    <= '0;
      bin_idx_q     <= '0;
      bin_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_drop_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      w_state_q     <= w_state_d;
      wr_bank_q     <= wr_bank_d;
      wr_cnt_q      <= wr_cnt_d;
      r_state_q     <= r_state_d;
      rd_bank_q     <= rd_bank_d;
      rd_idx_q      <= rd_idx_d;
      bank_st_q     <= bank_st_d;
      bin_data_q    <= bin_data_d;
      bin_idx_q     <= bin_idx_d;
      bin_valid_q   <= bin_valid_d;
      frame_start_q <= frame_start_d;
      frame_drop_q  <= frame_drop_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (wr_en) begin
      mem_q[wr_addr] <= fft_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[{rd_bank_q, rd_idx_q}];
    end
  end

  assign bin_data    = bin_data_q;
  assign bin_idx     = bin_idx_q;
  assign bin_valid   = bin_valid_q;
  assign frame_start = frame_start_q;
  assign frame_drop  = frame_drop_q;
  assign frame_err   = frame_err_q;

`ifdef SPEC_PEAK_HOLD_EN
  logic [DATA_W-1:0] peak_q [BIN_NUM];
  logic [DATA_W-1:0] peak_cur, peak_d, bin_peak_q;

  always_comb begin
    peak_cur = peak_q[rd_idx_q];
    if (rd_data_q >= peak_cur) begin
      peak_d = rd_data_q;
    end else begin
      peak_d = peak_cur - (peak_cur >> DECAY_SHIFT);
    end
  end

  // Updated in R_OUT so bin_peak changes on the same edge that raises bin_valid.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BIN_NUM; i++) begin
        peak_q[i] <= '0;
      end
      bin_peak_q <= '0;
    end else if (r_state_q == R_OUT) begin
      peak_q[rd_idx_q] <= peak_d;
      bin_peak_q       <= peak_d;
    end
  end

  assign bin_peak = bin_peak_q;
`endif

endmodule

// File: tb/tb_spectrum_buf_ctrl.sv
// Directed bench for spectrum_buf_ctrl: a frame-level vector table plus hand sequences
// for frame dropping, req during draw, mid-read reset and peak decay.
module tb_spectrum_buf_ctrl;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 6;
  localparam int NV      = 5;

  logic              clk_50m = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] fft_data;
  logic              fft_sop, fft_eop, fft_valid;
  logic              data_req, bin_done;
  logic [DATA_W-1:0] bin_data;
  logic [ADDR_W-1:0] bin_idx;
  logic              bin_valid, frame_start, frame_drop, frame_err;
`ifdef SPEC_PEAK_HOLD_EN
  logic [DATA_W-1:0] bin_peak;
  logic [DATA_W-1:0] peak5 = '0;
`endif

  typedef struct {
    int          len;
    int          restart_at;
    logic [15:0] base;
    logic [15:0] step;
    logic [15:0] exp_base;
    int          exp_err;
    int          exp_start;
  } vec_t;

  vec_t vecs [NV];

  int n_checks = 0;
  int n_err    = 0;
  int fs_cnt   = 0;
  int drop_cnt = 0;
  int err_cnt  = 0;
  int bv_cnt   = 0;

  always #10 clk_50m = ~clk_50m;

  spectrum_buf_ctrl dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .fft_data   (fft_data),
    .fft_sop    (fft_sop),
    .fft_eop    (fft_eop),
    .fft_valid  (fft_valid),
    .data_req   (data_req),
    .bin_done   (bin_done),
    .bin_data   (bin_data),
    .bin_idx    (bin_idx),
    .bin_valid  (bin_valid),
    .frame_start(frame_start),
    .frame_drop (frame_drop),
    .frame_err  (frame_err)
`ifdef SPEC_PEAK_HOLD_EN
    ,
    .bin_peak   (bin_peak)
`endif
  );

  // Pulse counters sampled mid-cycle.
  always @(negedge clk_50m) begin
    if (frame_start) fs_cnt++;
    if (frame_drop) drop_cnt++;
    if (frame_err) err_cnt++;
    if (bin_valid) bv_cnt++;
`ifdef SPEC_PEAK_HOLD_EN
    if (bin_valid && bin_idx == 6'd5) peak5 = bin_peak;
`endif
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] exp_val(input logic [15:0] b, input logic [15:0] st, input int i);
    return b + st * 16'(i);
  endfunction

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_frame(input logic [15:0] b, input logic [15:0] st, input int len,
                            input bit with_eop);
    for (int i = 0; i < len; i++) begin
      if (i % 9 == 4) begin
        fft_valid = 1'b0;
        fft_sop   = 1'b1;
        fft_eop   = 1'b1;
        fft_data  = 16'hDEAD;
        tick();
      end
      fft_valid = 1'b1;
      fft_sop   = (i == 0);
      fft_eop   = with_eop && (i == len - 1);
      fft_data  = exp_val(b, st, i);
      tick();
    end
    fft_valid = 1'b0;
    fft_sop   = 1'b0;
    fft_eop   = 1'b0;
  endtask

  task automatic read_bins(input logic [15:0] b, input logic [15:0] st, input int first,
                           input int last);
    for (int i = first; i <= last; i++) begin
      int n;
      n = 0;
      data_req = 1'b1;
      do begin
        tick();
        n++;
      end while (!bin_valid && n < 8);
      data_req = 1'b0;
      check($sformatf("latency[%0d]", i), n, 3);
      check($sformatf("bin_data[%0d]", i), int'(bin_data), int'(exp_val(b, st, i)));
      check($sformatf("bin_idx[%0d]", i), int'(bin_idx), i);
      bin_done = 1'b1;
      tick();
      bin_done = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bin_data"}, int'(bin_data), 0);
    check({tag, "_bin_idx"}, int'(bin_idx), 0);
    check({tag, "_bin_valid"}, int'(bin_valid), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_frame_drop"}, int'(frame_drop), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
  endtask

  initial begin
    int fs0, dr0, er0, bv0;
    logic [15:0] pk_base [3];
    int          pk_exp  [3];

    vecs[0] = '{128, -1, 16'd0,     16'd1, 16'd0,     0, 1};
    vecs[1] = '{128, -1, 16'd1000,  16'd7, 16'd1000,  0, 1};
    vecs[2] = '{40,  -1, 16'd200,   16'd1, 16'd200,   1, 0};
    vecs[3] = '{128, 50, 16'd500,   16'd3, 16'd3000,  1, 1};
    vecs[4] = '{128, -1, 16'hFFC0,  16'd1, 16'hFFC0,  0, 1};
    pk_base[0] = 16'd795;
    pk_base[1] = 16'hFFFB;
    pk_base[2] = 16'hFFFB;
    pk_exp[0]  = 800;
    pk_exp[1]  = 700;
    pk_exp[2]  = 613;

    rst_n     = 1'b0;
    fft_data  = '0;
    fft_sop   = 1'b0;
    fft_eop   = 1'b0;
    fft_valid = 1'b0;
    data_req  = 1'b0;
    bin_done  = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < NV; v++) begin
      fs0 = fs_cnt;
      er0 = err_cnt;
      dr0 = drop_cnt;
      if (vecs[v].restart_at < 0) begin
        send_frame(vecs[v].base, vecs[v].step, vecs[v].len, 1'b1);
      end else begin
        send_frame(vecs[v].base, vecs[v].step, vecs[v].restart_at, 1'b0);
        send_frame(vecs[v].exp_base, vecs[v].step, vecs[v].len, 1'b1);
      end
      repeat (3) tick();
      check($sformatf("v%0d_frame_start", v), fs_cnt - fs0, vecs[v].exp_start);
      check($sformatf("v%0d_frame_err", v), err_cnt - er0, vecs[v].exp_err);
      check($sformatf("v%0d_frame_drop", v), drop_cnt - dr0, 0);
      if (vecs[v].exp_start != 0) begin
        read_bins(vecs[v].exp_base, vecs[v].step, 0, 63);
        repeat (2) tick();
      end
      check($sformatf("v%0d_banks_free", v), int'(dut.bank_st_q), 0);
    end

    // Three frames while the reader is stalled on the first.
    fs0 = fs_cnt;
    dr0 = drop_cnt;
    send_frame(16'd100, 16'd1, 128, 1'b1);
    repeat (3) tick();
    check("stall_start1", fs_cnt - fs0, 1);
    read_bins(16'd100, 16'd1, 0, 9);
    send_frame(16'd2000, 16'd5, 128, 1'b1);
    send_frame(16'd4000, 16'd3, 128, 1'b1);
    repeat (3) tick();
    check("stall_drop", drop_cnt - dr0, 1);
    check("stall_no_start", fs_cnt - fs0, 1);
    read_bins(16'd100, 16'd1, 10, 63);
    repeat (3) tick();
    check("stall_start2", fs_cnt - fs0, 2);
    read_bins(16'd4000, 16'd3, 0, 63);
    repeat (2) tick();
    check("stall_drop_total", drop_cnt - dr0, 1);
    check("stall_banks_free", int'(dut.bank_st_q), 0);

    // data_req held through R_DRAW must not produce another bin.
    send_frame(16'd300, 16'd2, 128, 1'b1);
    repeat (3) tick();
    bv0 = bv_cnt;
    data_req = 1'b1;
    repeat (3) tick();
    check("held_req_valid", int'(bin_valid), 1);
    check("held_req_data", int'(bin_data), 300);
    repeat (5) tick();
    check("held_req_one_bin", bv_cnt - bv0, 1);
    data_req = 1'b0;
    bin_done = 1'b1;
    tick();
    bin_done = 1'b0;
    read_bins(16'd300, 16'd2, 1, 3);

    // Reset while a bin is on display.
    data_req = 1'b1;
    repeat (3) tick();
    data_req = 1'b0;
    check("pre_reset_data", int'(bin_data), 308);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) tick();
    rst_n = 1'b1;
    fs0 = fs_cnt;
    bv0 = bv_cnt;
    data_req = 1'b1;
    repeat (10) tick();
    data_req = 1'b0;
    check("post_reset_no_start", fs_cnt - fs0, 0);
    check("post_reset_no_bin", bv_cnt - bv0, 0);
    check("post_reset_banks_free", int'(dut.bank_st_q), 0);

    // Fresh frames after reset; bin 5 carries 800 then 0 twice.
    for (int k = 0; k < 3; k++) begin
      fs0 = fs_cnt;
      send_frame(pk_base[k], 16'd1, 128, 1'b1);
      repeat (3) tick();
      check($sformatf("pk%0d_start", k), fs_cnt - fs0, 1);
      read_bins(pk_base[k], 16'd1, 0, 63);
      repeat (2) tick();
`ifdef SPEC_PEAK_HOLD_EN
      check($sformatf("pk%0d_bin5_peak", k), int'(peak5), pk_exp[k]);
`else
      check($sformatf("pk%0d_banks_free", k), int'(dut.bank_st_q), pk_exp[k] - pk_exp[k]);
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
